seg7_scan_ctrl: RTL and testbench

- Multiplex scan controller for an N-digit common-cathode 7-segment display.
- Time-shares the single-digit BCD-to-7-segment decoder among DIGITS digits and sequences the digit-select lines.
- Inserts blanking between digits to stop ghosting, double-buffers display data so a frame never tears, and optionally suppresses leading zeros.
- Sits between application logic (e.g. counters, the 50 MHz demo top) and the existing BCD decoder plus the digit-enable pins.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_slot_timer.sv | 33 +++
 rtl/seg7_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg7_pkg;

    localparam logic [3:0] SEG7_BLANK_NIBBLE = 4'h0;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    function automatic int slot_cyc(input int clk_hz, input int slot_hz);
        return clk_hz / slot_hz;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter; flags the slot wrap and whether the next cycle
// falls inside the blanking window at the head of a slot.
module seg7_slot_timer #(
    parameter int SLOT_CYC  = 10,
    parameter int BLANK_CYC = 2,
    parameter int CW        = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_wrap,
    output logic in_blank
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        slot_wrap = (cnt_q == CW'(SLOT_CYC - 1));
        cnt_d     = slot_wrap ? '0 : cnt_q + CW'(1);
        // refers to the cycle after the coming edge, so the FSM can
        // register its outputs on the same edge as the counter moves
        in_blank  = (cnt_d < CW'(BLANK_CYC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplex scan controller for an N-digit common-cathode 7-segment display:
// slot sequencing, inter-digit blanking, tear-free double buffer, zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int SLOT_HZ   = 4_000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk50MHz,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    output logic [3:0]            bcd_out,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel_n,
    output logic                  frame_done
);

    localparam int SLOT_CYC = slot_cyc(CLK_HZ, SLOT_HZ);
    localparam int CW       = cnt_width(SLOT_CYC);
    localparam int IW       = cnt_width(DIGITS);

    logic slot_wrap;
    logic in_blank;

    seg7_slot_timer #(
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC),
        .CW        (CW)
    ) u_timer (
        .clk       (clk50MHz),
        .rst_n     (rst_n),
        .slot_wrap (slot_wrap),
        .in_blank  (in_blank)
    );

    scan_state_t         state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]          bcd_q, bcd_d;
    logic                dp_q, dp_d;
    logic                fd_q, fd_d;
    logic [4*DIGITS-1:0] act_q, act_d;
    logic [DIGITS-1:0]   adp_q, adp_d;
    logic [4*DIGITS-1:0] pend_q, pend_d;
    logic [DIGITS-1:0]   pdp_q, pdp_d;
    logic                pend_v_q, pend_v_d;

    logic [3:0]          nib_nxt;
    logic                dp_nxt;
    logic [DIGITS-1:0]   sel_on;
    logic [DIGITS-1:0]   lz_m;
    logic                blanked;

    // A digit is blanked only while every digit above it is blanked too,
    // so a lit decimal point ends the run of suppressed zeros.
    function automatic logic [DIGITS-1:0] lz_mask(
        input logic [4*DIGITS-1:0] nib,
        input logic [DIGITS-1:0]   dpv
    );
        logic              run;
        logic [DIGITS-1:0] m;
        run = 1'b1;
        m   = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run  = run & (nib[4*k +: 4] == 4'h0) & ~dpv[k];
            m[k] = run;
        end
        return m;
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BLANK:   if (!in_blank) state_d = DRIVE;
            DRIVE:   if (slot_wrap) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        fd_d  = 1'b0;
        if (slot_wrap) begin
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d = '0;
                fd_d  = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_comb begin
        act_d    = act_q;
        adp_d    = adp_q;
        pend_d   = pend_q;
        pdp_d    = pdp_q;
        pend_v_d = pend_v_q;
        if (fd_q) begin
            if (load) begin
                act_d    = bcd_in;
                adp_d    = dp_in;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                act_d    = pend_q;
                adp_d    = pdp_q;
                pend_v_d = 1'b0;
            end
        end else if (load) begin
            pend_d   = bcd_in;
            pdp_d    = dp_in;
            pend_v_d = 1'b1;
        end
    end

    always_comb begin
        nib_nxt = act_d[3:0];
        dp_nxt  = adp_d[0];
        sel_on  = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                nib_nxt   = act_d[4*k +: 4];
                dp_nxt    = adp_d[k];
                sel_on[k] = 1'b0;
            end
        end
        lz_m    = lz_mask(act_d, adp_d);
        blanked = lz_en && ((lz_m & ~sel_on) != '0);
    end

    // Select and dp are decided once per slot as DRIVE begins and then held.
    always_comb begin
        bcd_d = nib_nxt;
        sel_d = sel_q;
        dp_d  = dp_q;
        if (state_d == BLANK) begin
            sel_d = '1;
            dp_d  = 1'b0;
        end else if (state_q == BLANK) begin
            sel_d = blanked ? '1 : sel_on;
            dp_d  = dp_nxt & ~blanked;
        end
    end

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BLANK;
            idx_q    <= '0;
            sel_q    <= '1;
            bcd_q    <= SEG7_BLANK_NIBBLE;
            dp_q     <= 1'b0;
            fd_q     <= 1'b0;
            act_q    <= '0;
            adp_q    <= '0;
            pend_q   <= '0;
            pdp_q    <= '0;
            pend_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            bcd_q    <= bcd_d;
            dp_q     <= dp_d;
            fd_q     <= fd_d;
            act_q    <= act_d;
            adp_q    <= adp_d;
            pend_q   <= pend_d;
            pdp_q    <= pdp_d;
            pend_v_q <= pend_v_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign dp         = dp_q;
    assign dig_sel_n  = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a per-slot expectation queue.
// Bench timing: 10-cycle slots, 2 blank cycles, 4 digits.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  bcd_out;
    logic        dp;
    logic [3:0]  dig_sel_n;
    logic        frame_done;

    seg7_scan_ctrl #(
        .DIGITS    (4),
        .CLK_HZ    (1000),
        .SLOT_HZ   (100),
        .BLANK_CYC (2)
    ) dut (
        .clk50MHz   (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .bcd_out    (bcd_out),
        .dp         (dp),
        .dig_sel_n  (dig_sel_n),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] nib;
        logic       dp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fnum  = 0;
    int          cyc   = 0;

    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    logic        m_pv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s frame=%0d cyc=%0d got=%h want=%h",
                   tag, fnum, cyc, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_act  = '0;
        m_adp  = '0;
        m_pend = '0;
        m_pdp  = '0;
        m_pv   = 1'b0;
        sb.delete();
    endtask

    task automatic push_frame();
        logic run;
        logic bl;
        exp_t e [4];
        run = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            run = run && (m_act[4*k +: 4] == 4'h0) && !m_adp[k];
            bl  = lz_en && run && (k != 0);
            e[k].sel = 4'hF;
            if (!bl) e[k].sel[k] = 1'b0;
            e[k].nib = m_act[4*k +: 4];
            e[k].dp  = m_adp[k] && !bl;
        end
        for (int k = 0; k < 4; k++) sb.push_back(e[k]);
    endtask

    task automatic model_load(input bit first, input int i,
                              input logic [15:0] v, input logic [3:0] d);
        if (first || i != 0) begin
            m_pend = v;
            m_pdp  = d;
            m_pv   = 1'b1;
        end
    endtask

    // Starts and ends on a falling edge at slot-counter value 0 of digit 0.
    task automatic run_frame(input bit first,
                             input int la, input logic [15:0] va,
                             input logic [3:0] da,
                             input int lb, input logic [15:0] vb,
                             input logic [3:0] db);
        exp_t cur;
        int   c;
        cur = '0;
        if (!first) begin
            if (la == 0) begin
                m_act = va;
                m_adp = da;
                m_pv  = 1'b0;
            end else if (m_pv) begin
                m_act = m_pend;
                m_adp = m_pdp;
                m_pv  = 1'b0;
            end
        end
        push_frame();
        for (int i = 0; i < 40; i++) begin
            c   = i % 10;
            cyc = i;
            chk("frame_done", 16'(frame_done), 16'(i == 0 && !first));
            if (c < 2) begin
                chk("blank_sel", 16'(dig_sel_n), 16'hF);
                chk("blank_dp", 16'(dp), 16'h0);
            end
            if (c == 1 || c == 2) chk("sb_level", 16'(sb.size() > 0), 16'h1);
            if (c == 1 && sb.size() > 0)
                chk("settle_bcd", 16'(bcd_out), 16'(sb[0].nib));
            if (c == 2 && sb.size() > 0) cur = sb.pop_front();
            if (c == 2 || c == 9) begin
                chk("drive_sel", 16'(dig_sel_n), 16'(cur.sel));
                chk("drive_bcd", 16'(bcd_out), 16'(cur.nib));
                chk("drive_dp", 16'(dp), 16'(cur.dp));
            end
            if (i == la) begin
                load = 1'b1; bcd_in = va; dp_in = da;
                model_load(first, i, va, da);
            end else if (i == lb) begin
                load = 1'b1; bcd_in = vb; dp_in = db;
                model_load(first, i, vb, db);
            end
            @(negedge clk);
            load = 1'b0;
        end
        fnum++;
    endtask

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        bcd_in = '0;
        dp_in  = '0;
        lz_en  = 1'b0;
        model_reset();

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", 16'(dig_sel_n), 16'hF);
        chk("rst_bcd", 16'(bcd_out), 16'h0);
        chk("rst_dp", 16'(dp), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);
        rst_n = 1'b1;

        run_frame(1, 5, 16'h1234, 4'b0100, -1, '0, '0);
        run_frame(0, -1, '0, '0, -1, '0, '0);
        run_frame(0, 15, 16'h5678, 4'b0000, -1, '0, '0);
        run_frame(0, 5, 16'hAAAA, 4'b0000, 25, 16'h0009, 4'b0000);
        run_frame(0, -1, '0, '0, -1, '0, '0);
        run_frame(0, 0, 16'h4321, 4'b0000, -1, '0, '0);
        chk("pend_v", 16'(dut.pend_v_q), 16'h0);

        lz_en = 1'b1;
        run_frame(0, 0, 16'h0050, 4'b0000, -1, '0, '0);
        run_frame(0, 0, 16'h0000, 4'b0000, -1, '0, '0);
        run_frame(0, 0, 16'h0000, 4'b0100, -1, '0, '0);
        lz_en = 1'b0;
        run_frame(0, 0, 16'h9876, 4'b0100, -1, '0, '0);

        repeat (25) @(negedge clk);
        cyc = 25;
        chk("pre_rst_sel", 16'(dig_sel_n), 16'hB);
        chk("pre_rst_bcd", 16'(bcd_out), 16'h8);
        chk("pre_rst_dp", 16'(dp), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sel", 16'(dig_sel_n), 16'hF);
        chk("async_bcd", 16'(bcd_out), 16'h0);
        chk("async_dp", 16'(dp), 16'h0);
        chk("async_fd", 16'(frame_done), 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fnum++;
        run_frame(1, -1, '0, '0, -1, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
